// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface types for the instruction/data memory arbiter.
// Encodings follow the core's existing Bundle memory function and mask types.
package mem_arbiter_pkg;

    localparam int unsigned FCN_W = 1;
    localparam int unsigned TYP_W = 3;

    typedef enum logic [FCN_W-1:0] {
        M_XRD = 1'b0,
        M_XWR = 1'b1
    } MemoryWriteSignal;

    typedef enum logic [TYP_W-1:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_D  = 3'd4,
        MT_BU = 3'd5,
        MT_HU = 3'd6,
        MT_WU = 3'd7
    } MemoryMaskType;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } ArbState;

    typedef enum logic {
        SelI = 1'b0,
        SelD = 1'b1
    } ArbSel;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported memory, one transaction
// at a time, holding each completed response until the pipeline advances.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req_valid,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_resp_valid,
    output logic [DATA_W-1:0] imem_resp_data,
    input  logic              dmem_req_valid,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic [FCN_W-1:0]  dmem_fcn,
    input  logic [TYP_W-1:0]  dmem_typ,
    output logic              dmem_resp_valid,
    output logic [DATA_W-1:0] dmem_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [FCN_W-1:0]  mem_fcn,
    output logic [TYP_W-1:0]  mem_typ,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              cmiss_stall
);

    ArbState state_q, state_d;
    ArbSel   sel_q, sel_d;
    logic    i_done_q, i_done_d;
    logic    d_done_q, d_done_d;
    logic [DATA_W-1:0] i_data_q, i_data_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [FCN_W-1:0]  fcn_q, fcn_d;
    logic [TYP_W-1:0]  typ_q, typ_d;

    logic i_pend, d_pend;

    assign i_pend      = imem_req_valid && !i_done_q;
    assign d_pend      = dmem_req_valid && !d_done_q;
    assign cmiss_stall = i_pend || d_pend;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        i_done_d    = i_done_q;
        d_done_d    = d_done_q;
        i_data_d    = i_data_q;
        d_data_d    = d_data_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        fcn_d       = fcn_q;
        typ_d       = typ_q;

        case (state_q)
            StIdle: begin
                // Data first: it belongs to the older instruction in the pipeline.
                if (d_pend) begin
                    sel_d       = SelD;
                    addr_d      = dmem_addr;
                    wdata_d     = dmem_wdata;
                    fcn_d       = dmem_fcn;
                    typ_d       = dmem_typ;
                    req_valid_d = 1'b1;
                    state_d     = StReq;
                end else if (i_pend) begin
                    sel_d       = SelI;
                    addr_d      = imem_addr;
                    fcn_d       = M_XRD;
                    typ_d       = MT_W;
                    req_valid_d = 1'b1;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (mem_resp_valid) begin
                    state_d = StIdle;
                    // A port whose request dropped was killed; its response is discarded.
                    if (sel_q == SelI && imem_req_valid) begin
                        i_done_d = 1'b1;
                        i_data_d = mem_resp_data;
                    end else if (sel_q == SelD && dmem_req_valid) begin
                        d_done_d = 1'b1;
                        d_data_d = mem_resp_data;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                req_valid_d = 1'b0;
            end
        endcase

        if (!cmiss_stall) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= SelI;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_data_q    <= '0;
            d_data_q    <= '0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            fcn_q       <= '0;
            typ_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_data_q    <= i_data_d;
            d_data_q    <= d_data_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            fcn_q       <= fcn_d;
            typ_q       <= typ_d;
        end
    end

    assign imem_resp_valid = i_done_q;
    assign imem_resp_data  = i_data_q;
    assign dmem_resp_valid = d_done_q;
    assign dmem_resp_data  = d_data_q;
    assign mem_req_valid   = req_valid_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_fcn         = fcn_q;
    assign mem_typ         = typ_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the memory side is driven cycle by cycle with
// hand-timed ready/response strobes and every output checked against fixed values.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_resp_valid;
    logic [DATA_W-1:0] imem_resp_data;
    logic              dmem_req_valid;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [FCN_W-1:0]  dmem_fcn;
    logic [TYP_W-1:0]  dmem_typ;
    logic              dmem_resp_valid;
    logic [DATA_W-1:0] dmem_resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [FCN_W-1:0]  mem_fcn;
    logic [TYP_W-1:0]  mem_typ;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              cmiss_stall;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .dmem_req_valid (dmem_req_valid),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_fcn       (dmem_fcn),
        .dmem_typ       (dmem_typ),
        .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data (dmem_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_fcn        (mem_fcn),
        .mem_typ        (mem_typ),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .cmiss_stall    (cmiss_stall)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_valid = 1'b0; imem_addr = '0;
        dmem_req_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0;
        dmem_fcn = M_XRD; dmem_typ = MT_W;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++; if (imem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_imem_resp_valid got %b want 0", imem_resp_valid); end
        n_checks++; if (dmem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_resp_valid got %b want 0", dmem_resp_valid); end
        n_checks++; if (imem_resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_imem_resp_data got %h want 0", imem_resp_data); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got %b want 0", mem_req_valid); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_fields got addr %h wdata %h want 0", mem_addr, mem_wdata); end
        n_checks++; if (cmiss_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle got %b want 0", cmiss_stall); end
    endtask

    task automatic test_fetch_only();
        // cycle 0
        imem_req_valid = 1'b1; imem_addr = 32'h100; mem_req_ready = 1'b1;
        #1;
        n_checks++; if (cmiss_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0 got %b want 1", cmiss_stall); end
        tick(); // cycle 1: REQ
        n_checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_req_c1 got valid %b addr %h want 1 100", mem_req_valid, mem_addr); end
        n_checks++; if (mem_fcn !== M_XRD || mem_typ !== MT_W) begin n_fail++; $display("FAIL fetch_fcn_typ got %h %h want 0 3", mem_fcn, mem_typ); end
        tick(); // cycle 2: RESP
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_req_drop_c2 got %b want 0", mem_req_valid); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
        tick(); // cycle 3
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        n_checks++; if (imem_resp_valid !== 1'b1 || imem_resp_data !== 32'h13) begin n_fail++; $display("FAIL fetch_resp_c3 got %b %h want 1 00000013", imem_resp_valid, imem_resp_data); end
        n_checks++; if (cmiss_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c3 got %b want 0", cmiss_stall); end
        imem_req_valid = 1'b0;
        tick(); // cycle 4: done cleared, data kept
        n_checks++; if (imem_resp_valid !== 1'b0 || imem_resp_data !== 32'h13) begin n_fail++; $display("FAIL fetch_clear_c4 got %b %h want 0 00000013", imem_resp_valid, imem_resp_data); end
    endtask

    task automatic test_simultaneous();
        imem_req_valid = 1'b1; imem_addr = 32'h104;
        dmem_req_valid = 1'b1; dmem_addr = 32'h2000; dmem_fcn = M_XRD; dmem_typ = MT_W;
        mem_req_ready = 1'b1;
        tick(); // cycle 1
        n_checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h2000) begin n_fail++; $display("FAIL sim_first_addr got %b %h want 1 2000", mem_req_valid, mem_addr); end
        tick(); // cycle 2
        mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA_0001;
        tick(); // cycle 3
        mem_resp_valid = 1'b0;
        n_checks++; if (dmem_resp_valid !== 1'b1 || dmem_resp_data !== 32'hAAAA_0001 || imem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL sim_d_done got d %b %h i %b want 1 aaaa0001 0", dmem_resp_valid, dmem_resp_data, imem_resp_valid); end
        n_checks++; if (cmiss_stall !== 1'b1) begin n_fail++; $display("FAIL sim_stall_held got %b want 1", cmiss_stall); end
        tick(); // cycle 4
        n_checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h104 || mem_fcn !== M_XRD) begin n_fail++; $display("FAIL sim_second_addr got %b %h %h want 1 104 0", mem_req_valid, mem_addr, mem_fcn); end
        tick(); // cycle 5
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0093;
        tick(); // cycle 6
        mem_resp_valid = 1'b0;
        n_checks++; if (imem_resp_valid !== 1'b1 || imem_resp_data !== 32'h93 || dmem_resp_valid !== 1'b1) begin n_fail++; $display("FAIL sim_both_done got i %b %h d %b want 1 00000093 1", imem_resp_valid, imem_resp_data, dmem_resp_valid); end
        n_checks++; if (cmiss_stall !== 1'b0) begin n_fail++; $display("FAIL sim_stall_drop got %b want 0", cmiss_stall); end
        imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
        tick(); // cycle 7
        n_checks++; if (imem_resp_valid !== 1'b0 || dmem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL sim_clear got %b %b want 0 0", imem_resp_valid, dmem_resp_valid); end
    endtask

    task automatic test_backpressure();
        imem_req_valid = 1'b1; imem_addr = 32'h200; mem_req_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL bp_hold_c%0d got %b %h want 1 200", c, mem_req_valid, mem_addr); end
        end
        mem_req_ready = 1'b1;
        tick(); // cycle 5: RESP
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept got %b want 0", mem_req_valid); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
        tick(); // cycle 6
        mem_resp_valid = 1'b0;
        n_checks++; if (imem_resp_valid !== 1'b1 || imem_resp_data !== 32'h55) begin n_fail++; $display("FAIL bp_resp got %b %h want 1 00000055", imem_resp_valid, imem_resp_data); end
        imem_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_store();
        dmem_req_valid = 1'b1; dmem_addr = 32'h3000; dmem_wdata = 32'hDEAD_BEEF;
        dmem_fcn = M_XWR; dmem_typ = MT_W; mem_req_ready = 1'b1;
        tick(); // cycle 1
        n_checks++; if (mem_addr !== 32'h3000 || mem_wdata !== 32'hDEAD_BEEF || mem_fcn !== M_XWR) begin n_fail++; $display("FAIL store_req got %h %h %h want 3000 deadbeef 1", mem_addr, mem_wdata, mem_fcn); end
        tick(); // cycle 2
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0;
        tick(); // cycle 3
        mem_resp_valid = 1'b0;
        n_checks++; if (dmem_resp_valid !== 1'b1 || cmiss_stall !== 1'b0) begin n_fail++; $display("FAIL store_ack got valid %b stall %b want 1 0", dmem_resp_valid, cmiss_stall); end
        dmem_req_valid = 1'b0; dmem_fcn = M_XRD;
        tick();
    endtask

    task automatic test_kill();
        imem_req_valid = 1'b1; imem_addr = 32'h400; mem_req_ready = 1'b1;
        tick(); // cycle 1
        tick(); // cycle 2: RESP, fetch killed as the response arrives
        imem_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
        tick(); // cycle 3
        mem_resp_valid = 1'b0;
        n_checks++; if (imem_resp_valid !== 1'b0 || imem_resp_data !== 32'h55) begin n_fail++; $display("FAIL kill_discard got %b %h want 0 00000055", imem_resp_valid, imem_resp_data); end
        imem_req_valid = 1'b1; imem_addr = 32'h404;
        tick(); // cycle 4: back in REQ only if the FSM returned to IDLE
        n_checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h404) begin n_fail++; $display("FAIL kill_idle_return got %b %h want 1 404", mem_req_valid, mem_addr); end
        tick(); // cycle 5
        mem_resp_valid = 1'b1; mem_resp_data = 32'h99;
        tick(); // cycle 6
        mem_resp_valid = 1'b0;
        n_checks++; if (imem_resp_valid !== 1'b1 || imem_resp_data !== 32'h99) begin n_fail++; $display("FAIL kill_refetch got %b %h want 1 00000099", imem_resp_valid, imem_resp_data); end
        imem_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_req();
        imem_req_valid = 1'b1; imem_addr = 32'h500; mem_req_ready = 1'b0;
        tick(); // cycle 1: REQ
        n_checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h500) begin n_fail++; $display("FAIL rst_req_pre got %b %h want 1 500", mem_req_valid, mem_addr); end
        rst = 1'b1; imem_req_valid = 1'b0;
        #1;
        n_checks++; if (mem_req_valid !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_async got %b %h want 0 0", mem_req_valid, mem_addr); end
        tick();
        rst = 1'b0; mem_req_ready = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD;
        tick();
        mem_resp_valid = 1'b0;
        n_checks++; if (imem_resp_valid !== 1'b0 || imem_resp_data !== 32'h0 || dmem_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stray_resp got %b %h %b want 0 0 0", imem_resp_valid, imem_resp_data, dmem_resp_valid); end
        tick();
        n_checks++; if (mem_req_valid !== 1'b0 || cmiss_stall !== 1'b0) begin n_fail++; $display("FAIL rst_idle got %b %b want 0 0", mem_req_valid, cmiss_stall); end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_backpressure();
        test_store();
        test_kill();
        test_reset_in_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported backing memory between the core's instruction-fetch port and data port. It sequences one memory transaction at a time and holds each port's completed response until the pipeline advances. It generates the `cmiss_stall` signal consumed by the datapath and control. It sits between the datapath's `imem_in`/`dmem_in` request bundles and the unified memory.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports. Clock is `clk`; reset is `rst`, asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `imem_req_valid`  in  1  fetch request pending; held stable until the pipeline advances
- `imem_addr`  in  ADDR_W  fetch address
- `imem_resp_valid`  out  1  fetch data available
- `imem_resp_data`  out  DATA_W  fetched word
- `dmem_req_valid`  in  1  data request pending; held stable until the pipeline advances
- `dmem_addr`  in  ADDR_W  data address
- `dmem_wdata`  in  DATA_W  store data
- `dmem_fcn`  in  `Bundle::MemoryWriteSignal`  read/write function
- `dmem_typ`  in  `Bundle::MemoryMaskType`  access size
- `dmem_resp_valid`  out  1  data access complete
- `dmem_resp_data`  out  DATA_W  load data
- `mem_req_valid`  out  1  request to backing memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`, `mem_wdata`, `mem_fcn`, `mem_typ`  out  as the dmem equivalents  latched request
- `mem_resp_valid`  in  1  memory response strobe
- `mem_resp_data`  in  DATA_W  memory read data
- `cmiss_stall`  out  1  pipeline must hold

## Operation
- State registers:
  - FSM `state` ∈ {IDLE, REQ, RESP}.
  - `sel` ∈ {SEL_I, SEL_D}.
  - Done flags `i_done` and `d_done`.
  - Data registers `i_data` and `d_data`.
  - Latched request: addr, wdata, fcn, typ.
- A port is *pending* when `req_valid && !done`.
- `cmiss_stall = (imem_req_valid && !i_done) || (dmem_req_valid && !d_done)`. This is combinational.
- `imem_resp_valid = i_done`, `imem_resp_data = i_data`. The dmem outputs are driven the same way from `d_done`/`d_data`.
- IDLE:
  - If data is pending, set `sel`=SEL_D and latch the dmem fields. Data has priority, because it is the older instruction.
  - Otherwise, if fetch is pending, set `sel`=SEL_I and latch `imem_addr` with fcn=M_XRD and typ=MT_W.
  - In either case go to REQ. With nothing pending, stay in IDLE.
- REQ: `mem_req_valid`=1 with the latched fields. On `mem_req_ready` go to RESP.
- RESP: on `mem_resp_valid`:
  - If the selected port's `req_valid` is still 1, set its done flag and capture `mem_resp_data`. Writes also set `d_done`; `d_data` captures whatever is returned.
  - If the selected port's `req_valid` has dropped (killed), discard the response and leave the done flag unchanged.
  - In both cases go to IDLE.
- Done clear: on any edge where `cmiss_stall`=0, clear `i_done` and `d_done`. Do not clear the data registers.
- `mem_resp_valid` outside RESP is ignored.
- A write that has been issued always completes at memory, even if it is killed.

## Timing
- Reset values:
  - `state`=IDLE.
  - Done flags 0, so both resp_valid outputs are 0.
  - Data registers 0.
  - `mem_req_valid`=0 and `mem_*` fields 0.
  - `cmiss_stall` follows its inputs.
- Reset asserted mid-transaction returns to IDLE immediately. A later stray `mem_resp_valid` is ignored.
- Minimum latency with ready=1 and response one cycle after accept: the request is seen at cycle 0 (IDLE), REQ at cycle 1, RESP with `mem_resp_valid` at cycle 2, and `resp_valid` is 1 at cycle 3.
- Memory never returns a response in the same cycle it accepts a request.
- Both ports pending: data is served first, then fetch. `cmiss_stall` drops in the cycle after the fetch completes, and both done flags clear at that edge.
- `mem_*` outputs are registered and stable throughout REQ.

## Structure
- Add to `Bundle`:
  - enum `ArbState` {IDLE, REQ, RESP}
  - enum `ArbSel` {SEL_I, SEL_D}
- Reuse the existing `M_XRD`, `MT_W`, `MemoryWriteSignal` and `MemoryMaskType`.
- Single module with no sub-module. Use one `always_ff` with async reset and a combinational next-state block.

## Test plan
- Fetch only: `imem_addr`=0x100 with memory returning 0x00000013 one cycle after accept. Expect `imem_resp_valid`=1 and data 0x13 at cycle 3, and `cmiss_stall` 1→0 at cycle 3.
- Simultaneous requests: fetch 0x104 and load 0x2000. Expect the `mem_addr` order to be 0x2000 then 0x104. `d_done` is set first, `cmiss_stall` stays 1 until `i_done`, and both flags clear on the next edge.
- Backpressure: `mem_req_ready` low for 4 cycles. Expect `mem_req_valid` and `mem_addr` held constant, with the transaction completing after ready.
- Store: `dmem_fcn`=M_XWR, addr 0x3000, wdata 0xDEADBEEF. Expect `mem_wdata`=0xDEADBEEF, `mem_fcn`=M_XWR, and `dmem_resp_valid` set after the ack.
- Kill: drop `imem_req_valid` while in RESP. Expect the response discarded, `i_done` staying 0, and the FSM returning to IDLE.
- Reset in REQ: assert `rst` in REQ, then send a `mem_resp_valid` pulse. Expect IDLE, all outputs 0, and the pulse ignored.
